// File: rtl/exe_stage_pkg.sv
// Shared widths, opcodes and helpers for the execute stage.
package exe_stage_pkg;

  localparam int DSIZE = 16;
  localparam int ASIZE = 5;
  localparam int ISIZE = 16;
  localparam int CSIZE = $clog2(DSIZE);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } opcode_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // 01 selects the MEM forward, 10 the WB forward, anything else the regfile value.
  function automatic logic [DSIZE-1:0] fwd_mux(input logic [1:0]       sel,
                                               input logic [DSIZE-1:0] reg_val,
                                               input logic [DSIZE-1:0] mem_val,
                                               input logic [DSIZE-1:0] wb_val);
    case (sel)
      2'b01:   return mem_val;
      2'b10:   return wb_val;
      default: return reg_val;
    endcase
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE inputs, forwarding inputs and EXE/MEM outputs of the execute stage.
interface exe_stage_if;
  import exe_stage_pkg::*;

  logic [DSIZE-1:0] rdata1_in;
  logic [DSIZE-1:0] rdata2_in;
  logic [DSIZE-1:0] imm_in;
  logic [2:0]       opcode_in;
  logic             alusrc_in;
  logic [ASIZE-1:0] waddr_in;
  logic             wen_in;
  logic             memWrite_in;
  logic             memRead_in;
  logic             memToReg_in;
  logic             branch_in;
  logic [ISIZE-1:0] PC_in;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [DSIZE-1:0] mem_fwd_data;
  logic [DSIZE-1:0] wb_fwd_data;

  logic             stall_out;
  logic [DSIZE-1:0] alu_result_out;
  logic [DSIZE-1:0] store_data_out;
  logic [ASIZE-1:0] waddr_out;
  logic             wen_out;
  logic             memWrite_out;
  logic             memRead_out;
  logic             memToReg_out;
  logic             branch_taken_out;
  logic [ISIZE-1:0] branch_target_out;

  modport master (
    output rdata1_in, rdata2_in, imm_in, opcode_in, alusrc_in, waddr_in,
           wen_in, memWrite_in, memRead_in, memToReg_in, branch_in, PC_in,
           fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
    input  stall_out, alu_result_out, store_data_out, waddr_out, wen_out,
           memWrite_out, memRead_out, memToReg_out, branch_taken_out,
           branch_target_out
  );

  modport slave (
    input  rdata1_in, rdata2_in, imm_in, opcode_in, alusrc_in, waddr_in,
           wen_in, memWrite_in, memRead_in, memToReg_in, branch_in, PC_in,
           fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
    output stall_out, alu_result_out, store_data_out, waddr_out, wen_out,
           memWrite_out, memRead_out, memToReg_out, branch_taken_out,
           branch_target_out
  );

endinterface

// File: rtl/exe_stage_mul_seq.sv
// Shift-add multiplier: one partial product per BUSY cycle, DSIZE steps after start.
// Latency: start in IDLE, done during the BUSY cycle with cnt==0; product valid combinationally then.
module exe_stage_mul_seq
  import exe_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  output logic             busy,
  output logic [CSIZE-1:0] cnt,
  output logic             done,
  output logic [DSIZE-1:0] product
);

  mul_state_e       state;
  logic [DSIZE-1:0] acc;
  logic [DSIZE-1:0] mcand;
  logic [DSIZE-1:0] mplier;
  logic [DSIZE-1:0] addend;

  assign addend  = mplier[0] ? mcand : '0;
  assign busy    = (state == MUL_BUSY);
  assign done    = busy && (cnt == '0);
  // Includes the step of the current cycle so the final step needs no extra register stage.
  assign product = acc + addend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            state  <= MUL_BUSY;
            cnt    <= CSIZE'(DSIZE - 1);
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
          end
        end
        MUL_BUSY: begin
          acc    <= product;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) begin
            state <= MUL_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, ALU, branch resolution and the EXE/MEM output register.
// Latency: 1 edge for ALU ops, DSIZE+1 for MUL; stall_out holds the front end during a multiply.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  exe_stage_if.slave bus
);

  logic [DSIZE-1:0] op_a;
  logic [DSIZE-1:0] b_raw;
  logic [DSIZE-1:0] op_b;
  logic [DSIZE-1:0] alu_res;
  logic [DSIZE-1:0] cmp_diff;
  logic [ISIZE-1:0] target;
  logic             squash;
  logic             is_mul;
  logic             br_taken;

  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [CSIZE-1:0] mul_cnt;
  logic [DSIZE-1:0] mul_prod;

  logic [ASIZE-1:0] mul_waddr;
  logic [DSIZE-1:0] mul_store;
  logic             mul_wen;
  logic             mul_mw;
  logic             mul_mr;
  logic             mul_m2r;

  assign op_a     = fwd_mux(bus.fwd_a_sel, bus.rdata1_in, bus.mem_fwd_data, bus.wb_fwd_data);
  assign b_raw    = fwd_mux(bus.fwd_b_sel, bus.rdata2_in, bus.mem_fwd_data, bus.wb_fwd_data);
  assign op_b     = bus.alusrc_in ? bus.imm_in : b_raw;
  assign cmp_diff = op_a - b_raw;
  assign target   = bus.PC_in + ISIZE'(1) + bus.imm_in[ISIZE-1:0];

  // A taken branch on the outputs kills whatever sits in EXE this cycle.
  assign squash    = bus.branch_taken_out;
  assign is_mul    = (bus.opcode_in == OP_MUL);
  assign br_taken  = bus.branch_in && (cmp_diff == '0);
  assign mul_start = !mul_busy && is_mul && !squash;

  assign bus.stall_out = rst && (mul_start || (mul_busy && (mul_cnt != '0)));

  always_comb begin
    alu_res = '0;
    case (opcode_e'(bus.opcode_in))
      OP_ADD:         alu_res = op_a + op_b;
      OP_SUB, OP_CMP: alu_res = op_a - op_b;
      OP_AND:         alu_res = op_a & op_b;
      OP_OR:          alu_res = op_a | op_b;
      OP_XOR:         alu_res = op_a ^ op_b;
      OP_SLT:         alu_res = {{(DSIZE-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default:        alu_res = '0;
    endcase
  end

  exe_stage_mul_seq u_mul_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .cnt     (mul_cnt),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.alu_result_out    <= '0;
      bus.store_data_out    <= '0;
      bus.waddr_out         <= '0;
      bus.wen_out           <= 1'b0;
      bus.memWrite_out      <= 1'b0;
      bus.memRead_out       <= 1'b0;
      bus.memToReg_out      <= 1'b0;
      bus.branch_taken_out  <= 1'b0;
      bus.branch_target_out <= '0;
      mul_waddr             <= '0;
      mul_store             <= '0;
      mul_wen               <= 1'b0;
      mul_mw                <= 1'b0;
      mul_mr                <= 1'b0;
      mul_m2r               <= 1'b0;
    end else begin
      // The ID/EXE inputs may already belong to the next instruction when the product lands.
      if (mul_start) begin
        mul_waddr <= bus.waddr_in;
        mul_store <= b_raw;
        mul_wen   <= bus.wen_in;
        mul_mw    <= bus.memWrite_in;
        mul_mr    <= bus.memRead_in;
        mul_m2r   <= bus.memToReg_in;
      end

      if (mul_done) begin
        bus.alu_result_out   <= mul_prod;
        bus.store_data_out   <= mul_store;
        bus.waddr_out        <= mul_waddr;
        bus.wen_out          <= mul_wen;
        bus.memWrite_out     <= mul_mw;
        bus.memRead_out      <= mul_mr;
        bus.memToReg_out     <= mul_m2r;
        bus.branch_taken_out <= 1'b0;
      end else if (squash || mul_start || mul_busy) begin
        bus.wen_out          <= 1'b0;
        bus.memWrite_out     <= 1'b0;
        bus.memRead_out      <= 1'b0;
        bus.memToReg_out     <= 1'b0;
        bus.branch_taken_out <= 1'b0;
      end else begin
        bus.alu_result_out    <= alu_res;
        bus.store_data_out    <= b_raw;
        bus.waddr_out         <= bus.waddr_in;
        bus.wen_out           <= bus.wen_in;
        bus.memWrite_out      <= bus.memWrite_in;
        bus.memRead_out       <= bus.memRead_in;
        bus.memToReg_out      <= bus.memToReg_in;
        bus.branch_taken_out  <= br_taken;
        bus.branch_target_out <= target;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized and directed bench for exe_stage against an instruction-level reference model.
module tb_exe_stage;
  import exe_stage_pkg::*;

  typedef struct {
    logic [DSIZE-1:0] r1, r2, imm, mem, wb;
    logic [2:0]       op;
    logic             alusrc;
    logic [ASIZE-1:0] waddr;
    logic             wen, mw, mr, m2r, br;
    logic [ISIZE-1:0] pc;
    logic [1:0]       fa, fb;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   dut_stall_cnt = 0;
  bit   cmp_en = 1'b0;

  // Reference model state: a multiply in flight is just a countdown and a precomputed product.
  int               mul_left = 0;
  logic [DSIZE-1:0] m_prod, m_store;
  logic [ASIZE-1:0] m_waddr;
  logic             m_wen, m_mw, m_mr, m_m2r;

  logic [DSIZE-1:0] exp_res = '0, exp_store = '0;
  logic [ASIZE-1:0] exp_waddr = '0;
  logic             exp_wen = 0, exp_mw = 0, exp_mr = 0, exp_m2r = 0, exp_taken = 0;
  logic [ISIZE-1:0] exp_tgt = '0;
  bit               exp_valid = 0, exp_tgt_valid = 0, exp_stall = 0;

  always #5 clk = ~clk;

  exe_stage_if bus ();
  exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DSIZE-1:0] pick(input logic [1:0] s, input logic [DSIZE-1:0] r,
                                            input logic [DSIZE-1:0] m, input logic [DSIZE-1:0] w);
    if (s == 2'b01) return m;
    if (s == 2'b10) return w;
    return r;
  endfunction

  function automatic longint to_signed(input logic [DSIZE-1:0] v);
    return v[DSIZE-1] ? longint'(v) - (longint'(1) << DSIZE) : longint'(v);
  endfunction

  function automatic logic [DSIZE-1:0] alu_ref(input logic [2:0] op, input logic [DSIZE-1:0] a,
                                               input logic [DSIZE-1:0] b);
    longint m;
    m = longint'(1) << DSIZE;
    case (op)
      OP_ADD:         return DSIZE'((longint'(a) + longint'(b)) % m);
      OP_SUB, OP_CMP: return DSIZE'((longint'(a) - longint'(b) + m) % m);
      OP_AND:         return a & b;
      OP_OR:          return a | b;
      OP_XOR:         return a ^ b;
      OP_SLT:         return (to_signed(a) < to_signed(b)) ? DSIZE'(1) : DSIZE'(0);
      default:        return DSIZE'((longint'(a) * longint'(b)) % m);
    endcase
  endfunction

  function automatic instr_t nop();
    instr_t I;
    I.r1 = '0; I.r2 = '0; I.imm = '0; I.mem = '0; I.wb = '0;
    I.op = OP_ADD; I.alusrc = 0; I.waddr = '0;
    I.wen = 0; I.mw = 0; I.mr = 0; I.m2r = 0; I.br = 0;
    I.pc = '0; I.fa = 2'b00; I.fb = 2'b00;
    return I;
  endfunction

  function automatic instr_t rand_instr();
    instr_t I;
    I.op     = 3'($urandom_range(0, 7));
    I.r1     = ($urandom_range(0, 3) == 0) ? DSIZE'($urandom_range(0, 15)) : DSIZE'($urandom);
    I.r2     = ($urandom_range(0, 3) == 0) ? DSIZE'($urandom_range(0, 15)) : DSIZE'($urandom);
    I.imm    = DSIZE'($urandom);
    I.mem    = DSIZE'($urandom);
    I.wb     = DSIZE'($urandom);
    I.alusrc = 1'($urandom_range(0, 1));
    I.waddr  = ASIZE'($urandom);
    I.wen    = 1'($urandom_range(0, 1));
    I.mw     = 1'($urandom_range(0, 1));
    I.mr     = 1'($urandom_range(0, 1));
    I.m2r    = 1'($urandom_range(0, 1));
    I.pc     = ISIZE'($urandom);
    I.fa     = 2'($urandom_range(0, 3));
    I.fb     = 2'($urandom_range(0, 3));
    I.br     = (I.op != OP_MUL) && ($urandom_range(0, 2) == 0);
    if (I.br && ($urandom_range(0, 1) == 1)) begin
      I.fa = 2'b00; I.fb = 2'b11; I.r2 = I.r1;
    end
    return I;
  endfunction

  task automatic drive(input instr_t I);
    bus.rdata1_in = I.r1;  bus.rdata2_in = I.r2;  bus.imm_in = I.imm;
    bus.opcode_in = I.op;  bus.alusrc_in = I.alusrc; bus.waddr_in = I.waddr;
    bus.wen_in = I.wen;    bus.memWrite_in = I.mw; bus.memRead_in = I.mr;
    bus.memToReg_in = I.m2r; bus.branch_in = I.br; bus.PC_in = I.pc;
    bus.fwd_a_sel = I.fa;  bus.fwd_b_sel = I.fb;
    bus.mem_fwd_data = I.mem; bus.wb_fwd_data = I.wb;
  endtask

  task automatic model_reset();
    mul_left = 0;
    exp_res = '0; exp_store = '0; exp_waddr = '0; exp_tgt = '0;
    exp_wen = 0; exp_mw = 0; exp_mr = 0; exp_m2r = 0; exp_taken = 0;
    exp_valid = 0; exp_tgt_valid = 0; exp_stall = 0;
  endtask

  task automatic bubble();
    exp_wen = 0; exp_mw = 0; exp_mr = 0; exp_m2r = 0; exp_taken = 0; exp_valid = 0;
  endtask

  // One clock of the pipeline with I held on the ID/EXE outputs.
  task automatic run_cycle(input instr_t I, output bit consumed);
    logic [DSIZE-1:0] a, braw, b;
    bit squash, st;
    drive(I);
    #1;
    if (bus.stall_out) dut_stall_cnt++;
    a = pick(I.fa, I.r1, I.mem, I.wb);
    braw = pick(I.fb, I.r2, I.mem, I.wb);
    b = I.alusrc ? I.imm : braw;
    squash = exp_taken;
    if (mul_left > 0) begin
      st = (mul_left > 1);
    end else if (!squash && I.op == OP_MUL) begin
      mul_left = DSIZE + 1;
      m_prod = alu_ref(OP_MUL, a, b); m_store = braw; m_waddr = I.waddr;
      m_wen = I.wen; m_mw = I.mw; m_mr = I.mr; m_m2r = I.m2r;
      st = 1;
    end else begin
      st = 0;
    end
    exp_stall = st;
    @(posedge clk);
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        exp_res = m_prod; exp_store = m_store; exp_waddr = m_waddr;
        exp_wen = m_wen; exp_mw = m_mw; exp_mr = m_mr; exp_m2r = m_m2r;
        exp_taken = 0; exp_valid = 1; exp_tgt_valid = 0;
      end else begin
        bubble();
      end
    end else if (squash) begin
      bubble();
    end else begin
      exp_res = alu_ref(I.op, a, b); exp_store = braw; exp_waddr = I.waddr;
      exp_wen = I.wen; exp_mw = I.mw; exp_mr = I.mr; exp_m2r = I.m2r;
      exp_taken = I.br && (alu_ref(OP_SUB, a, braw) == '0);
      exp_tgt = ISIZE'((longint'(I.pc) + 1 + longint'(I.imm[ISIZE-1:0])) % (longint'(1) << ISIZE));
      exp_valid = 1; exp_tgt_valid = 1;
    end
    consumed = !st;
    #1;
  endtask

  task automatic issue(input instr_t I, output int ncyc);
    bit c;
    ncyc = 0;
    do begin
      run_cycle(I, c);
      ncyc++;
    end while (!c && ncyc < 4 * DSIZE);
    if (!c) chk("issue_timeout", 32'(ncyc), 32'(0));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall_out", 32'(bus.stall_out), 32'(exp_stall));
      chk("wen_out", 32'(bus.wen_out), 32'(exp_wen));
      chk("memWrite_out", 32'(bus.memWrite_out), 32'(exp_mw));
      chk("memRead_out", 32'(bus.memRead_out), 32'(exp_mr));
      chk("memToReg_out", 32'(bus.memToReg_out), 32'(exp_m2r));
      chk("branch_taken_out", 32'(bus.branch_taken_out), 32'(exp_taken));
      if (exp_valid) begin
        chk("alu_result_out", 32'(bus.alu_result_out), 32'(exp_res));
        chk("store_data_out", 32'(bus.store_data_out), 32'(exp_store));
        chk("waddr_out", 32'(bus.waddr_out), 32'(exp_waddr));
        if (exp_tgt_valid) chk("branch_target_out", 32'(bus.branch_target_out), 32'(exp_tgt));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(bus.stall_out), 32'(0));
    chk({tag, "_result"}, 32'(bus.alu_result_out), 32'(0));
    chk({tag, "_target"}, 32'(bus.branch_target_out), 32'(0));
    chk({tag, "_ctrl"}, 32'({bus.wen_out, bus.memWrite_out, bus.memRead_out,
                             bus.memToReg_out, bus.branch_taken_out}), 32'(0));
  endtask

  initial begin
    instr_t I;
    int nc;
    bit c;

    drive(nop());
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    cmp_en = 1'b1;

    // ADD with operand A from the MEM forward path.
    I = nop(); I.op = OP_ADD; I.fa = 2'b01; I.mem = 16'h0005; I.r1 = 16'h0999;
    I.r2 = 16'h0003; I.wen = 1; I.waddr = 5'd7;
    issue(I, nc);
    chk("add_result", 32'(bus.alu_result_out), 32'h0008);
    chk("add_wen", 32'(bus.wen_out), 32'(1));
    chk("add_latency", 32'(nc), 32'(1));

    I = nop(); I.op = OP_SLT; I.r1 = 16'hFFFF; I.r2 = 16'h0001;
    issue(I, nc);
    chk("slt_neg_lt_pos", 32'(bus.alu_result_out), 32'h0001);
    I.r1 = 16'h0001; I.r2 = 16'hFFFF;
    issue(I, nc);
    chk("slt_pos_lt_neg", 32'(bus.alu_result_out), 32'h0000);

    I = nop(); I.op = OP_MUL; I.r1 = 16'd7; I.r2 = 16'd6; I.wen = 1; I.waddr = 5'd9;
    dut_stall_cnt = 0;
    issue(I, nc);
    chk("mul_stall_cycles", 32'(dut_stall_cnt), 32'(DSIZE));
    chk("mul_occupancy", 32'(nc), 32'(DSIZE + 1));
    chk("mul_result", 32'(bus.alu_result_out), 32'h002A);
    chk("mul_wen", 32'(bus.wen_out), 32'(1));

    I.r1 = 16'h0100; I.r2 = 16'h0100;
    issue(I, nc);
    chk("mul_wrap", 32'(bus.alu_result_out), 32'h0000);

    I = nop(); I.op = OP_CMP; I.br = 1; I.r1 = 16'h1234; I.r2 = 16'h1234;
    I.pc = 16'h0010; I.imm = 16'h0004;
    issue(I, nc);
    chk("beq_taken", 32'(bus.branch_taken_out), 32'(1));
    chk("beq_target", 32'(bus.branch_target_out), 32'h0015);
    I = nop(); I.op = OP_ADD; I.wen = 1; I.r1 = 16'h0001;
    issue(I, nc);
    chk("squash_wen", 32'(bus.wen_out), 32'(0));
    chk("squash_pulse", 32'(bus.branch_taken_out), 32'(0));

    I = nop(); I.op = OP_CMP; I.br = 1; I.pc = 16'h0020; I.imm = 16'hFFFE;
    issue(I, nc);
    I = nop(); I.op = OP_MUL; I.r1 = 16'd3; I.r2 = 16'd3; I.wen = 1;
    dut_stall_cnt = 0;
    issue(I, nc);
    chk("squashed_mul_stall", 32'(dut_stall_cnt), 32'(0));
    chk("squashed_mul_wen", 32'(bus.wen_out), 32'(0));

    // Reset in the middle of a multiply.
    I = nop(); I.op = OP_MUL; I.r1 = 16'd3; I.r2 = 16'd5; I.wen = 1;
    for (int k = 0; k < 5; k++) run_cycle(I, c);
    cmp_en = 1'b0;
    #2; rst = 1'b0; #1;
    chk_all_zero("midmul_reset");
    model_reset();
    I = nop(); I.op = OP_ADD; I.r1 = 16'h0011; I.r2 = 16'h0022; I.wen = 1; I.waddr = 5'd3;
    drive(I);
    @(posedge clk); #3;
    rst = 1'b1;
    cmp_en = 1'b1;
    issue(I, nc);
    chk("post_reset_add", 32'(bus.alu_result_out), 32'h0033);
    chk("post_reset_latency", 32'(nc), 32'(1));

    for (int n = 0; n < 400; n++) begin
      issue(rand_instr(), nc);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
